// File: rtl/jpeg_ecs_bit_reader.sv
`default_nettype none
// ============================================================================
//  Module   : jpeg_ecs_bit_reader
//  Function : JPEG ECS front end: strips 0xFF00 stuffing, holds markers and
//             presents a left-aligned MSB-first bit window to the decoder.
//             Optional macro JPEG_BITRD_PAD1_EN: 1-padding of the window and
//             silent saturation of over-consume while a marker is held.
//  Revision : 1.0  initial release
// ============================================================================
module jpeg_ecs_bit_reader #(
    parameter int WIN_W = 16,
    parameter int BUF_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [WIN_W-1:0] out_bits,
    output logic [5:0]       out_avail,
    input  logic             consume_valid,
    input  logic [4:0]       consume_len,
    output logic             marker_valid,
    output logic [7:0]       marker_code,
    output logic             marker_is_rst,
    input  logic             marker_ack,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FF_SEEN = 2'd1,
        ST_MARKER  = 2'd2
    } state_t;

    localparam logic [5:0] ACCEPT_MAX = 6'(BUF_W - 8);

    state_t           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [5:0]       fill_q, fill_d;
    logic [7:0]       marker_code_q, marker_code_d;
    logic             err_q, err_d;

    logic             accept;
    logic             do_consume;
    logic             over;
    logic             append;
    logic [7:0]       append_byte;
    logic [BUF_W-1:0] buf_after;
    logic [5:0]       fill_after;

    // Registers only: no combinational path from the consume side.
    assign in_ready = (state_q != ST_MARKER) && (fill_q <= ACCEPT_MAX);

    always_comb begin
        state_d       = state_q;
        marker_code_d = marker_code_q;
        err_d         = err_q;
        append        = 1'b0;
        append_byte   = in_data;
        buf_after     = buf_q;
        fill_after    = fill_q;

        accept     = in_valid && in_ready;
        do_consume = consume_valid && (consume_len != 5'd0);
        over       = do_consume && ({1'b0, consume_len} > fill_q);

        // Consume is applied first so a same-cycle byte lands at fill - len.
        if (do_consume) begin
            if (over) begin
                buf_after  = '0;
                fill_after = '0;
`ifdef JPEG_BITRD_PAD1_EN
                if (state_q != ST_MARKER) begin
                    err_d = 1'b1;
                end
`else
                err_d = 1'b1;
`endif
            end else begin
                buf_after  = buf_q << consume_len;
                fill_after = fill_q - {1'b0, consume_len};
            end
        end

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (in_data == 8'hFF) begin
                        state_d = ST_FF_SEEN;
                    end else begin
                        append = 1'b1;
                    end
                end
            end
            ST_FF_SEEN: begin
                if (accept) begin
                    if (in_data == 8'h00) begin
                        append      = 1'b1;
                        append_byte = 8'hFF;
                        state_d     = ST_RUN;
                    end else if (in_data != 8'hFF) begin
                        marker_code_d = in_data;
                        state_d       = ST_MARKER;
                    end
                end
            end
            ST_MARKER: begin
                if (marker_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        buf_d  = buf_after;
        fill_d = fill_after;
        if (append) begin
            buf_d  = buf_after | ({append_byte, {(BUF_W-8){1'b0}}} >> fill_after);
            fill_d = fill_after + 6'd8;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            buf_q         <= '0;
            fill_q        <= '0;
            marker_code_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            fill_q        <= fill_d;
            marker_code_q <= marker_code_d;
            err_q         <= err_d;
        end
    end

`ifdef JPEG_BITRD_PAD1_EN
    logic [BUF_W-1:0] pad_mask;
    // Ones at every position at or beyond fill.
    assign pad_mask = {BUF_W{1'b1}} >> fill_q;
    assign out_bits = buf_q[BUF_W-1 -: WIN_W] |
                      ((state_q == ST_MARKER) ? pad_mask[BUF_W-1 -: WIN_W] : {WIN_W{1'b0}});
`else
    assign out_bits = buf_q[BUF_W-1 -: WIN_W];
`endif

    assign out_avail     = fill_q;
    assign marker_valid  = (state_q == ST_MARKER);
    assign marker_code   = marker_code_q;
    assign marker_is_rst = (marker_code_q[7:3] == 5'b11010);
    assign err           = err_q;

endmodule
`default_nettype wire
